// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - operand-side sequencer for the 16-bit combinational ALU
// Reads operands from a small register file, drives the ALU, captures and writes back the result.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic              ins_mode,
  input  logic [3:0]        ins_select,
  input  logic [AW-1:0]     ins_ra,
  input  logic [AW-1:0]     ins_rb,
  input  logic [AW-1:0]     ins_rd,
  input  logic              ins_use_carry,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [3:0]        alu_select,
  output logic              alu_mode,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry_out,
  input  logic              alu_compare,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [AW-1:0]     res_rd,
  output logic              res_carry,
  output logic              res_compare,
  output logic              carry_flag
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, DONE} state_t;

  state_t state, state_nxt;

  logic              op_mode;
  logic [3:0]        op_select;
  logic [AW-1:0]     op_ra;
  logic [AW-1:0]     op_rb;
  logic [AW-1:0]     op_rd;
  logic              op_use_carry;
  logic [DATA_W-1:0] rf [REG_N];

  logic accept;
  logic ext_wr;

  assign ins_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = ins_valid && ins_ready;
  assign ext_wr    = wr_en && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // External loads and write-back never collide: one is IDLE-only, the other CAPT-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      if (ext_wr)          rf[wr_addr] <= wr_data;
      if (state == CAPT)   rf[op_rd]   <= alu_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_mode      <= 1'b0;
      op_select    <= '0;
      op_ra        <= '0;
      op_rb        <= '0;
      op_rd        <= '0;
      op_use_carry <= 1'b0;
    end else if (accept) begin
      op_mode      <= ins_mode;
      op_select    <= ins_select;
      op_ra        <= ins_ra;
      op_rb        <= ins_rb;
      op_rd        <= ins_rd;
      op_use_carry <= ins_use_carry;
    end
  end

  // ALU inputs load in DRIVE and stay put until the next op reaches DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
    end else if (state == DRIVE) begin
      alu_in_a     <= rf[op_ra];
      alu_in_b     <= rf[op_rb];
      alu_select   <= op_select;
      alu_mode     <= op_mode;
      alu_carry_in <= op_use_carry & carry_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data    <= '0;
      res_rd      <= '0;
      res_carry   <= 1'b0;
      res_compare <= 1'b0;
      carry_flag  <= 1'b0;
    end else if (state == CAPT) begin
      res_data    <= alu_out;
      res_rd      <= op_rd;
      res_carry   <= alu_carry_out;
      res_compare <= alu_compare;
      if (!op_mode) carry_flag <= alu_carry_out;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU model
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic        ins_ready;
  logic        ins_mode;
  logic [3:0]  ins_select;
  logic [2:0]  ins_ra, ins_rb, ins_rd;
  logic        ins_use_carry;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] alu_in_a, alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_out;
  logic        alu_carry_out;
  logic        alu_compare;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        res_carry;
  logic        res_compare;
  logic        carry_flag;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        carry;
    logic        cmp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_mode(ins_mode),
    .ins_select(ins_select), .ins_ra(ins_ra), .ins_rb(ins_rb), .ins_rd(ins_rd),
    .ins_use_carry(ins_use_carry),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
    .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_carry(res_carry), .res_compare(res_compare),
    .carry_flag(carry_flag)
  );

  // Behavioural ALU: only the functions the vectors use.
  logic [16:0] sum;
  always_comb begin
    sum           = '0;
    alu_out       = '0;
    alu_carry_out = 1'b0;
    case ({alu_mode, alu_select})
      5'b0_1001: begin
        sum           = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
        alu_out       = sum[15:0];
        alu_carry_out = sum[16];
      end
      5'b1_0110: alu_out = alu_in_a ^ alu_in_b;
      5'b1_1111: alu_out = alu_in_a;
      default:   alu_out = '0;
    endcase
    alu_compare = (alu_in_a == alu_in_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {16'd0, res_data}, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data",    {16'd0, res_data}, {16'd0, e.data});
        check("res_rd",      {29'd0, res_rd},   {29'd0, e.rd});
        check("res_carry",   {31'd0, res_carry},   {31'd0, e.carry});
        check("res_compare", {31'd0, res_compare}, {31'd0, e.cmp});
      end
    end
  end

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Returns 1 ns after the accept edge.
  task automatic issue(input logic m, input logic [3:0] s, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd, input logic uc,
                       input logic [15:0] d, input logic c, input logic cmp, input logic push);
    exp_t e;
    int   k;
    k = 0;
    while (!ins_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ins_ready) check("ins_ready_timeout", 32'd0, 32'd1);
    e.data = d; e.rd = rd; e.carry = c; e.cmp = cmp;
    if (push) sb.push_back(e);
    ins_valid = 1'b1; ins_mode = m; ins_select = s;
    ins_ra = ra; ins_rb = rb; ins_rd = rd; ins_use_carry = uc;
    @(posedge clk); #1;
    ins_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || !ins_ready) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0 || !ins_ready) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; ins_valid = 1'b0; ins_mode = 1'b0; ins_select = '0;
    ins_ra = '0; ins_rb = '0; ins_rd = '0; ins_use_carry = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ins_ready",  {31'd0, ins_ready},  32'd1);
    check("reset_res_valid",  {31'd0, res_valid},  32'd0);
    check("reset_carry_flag", {31'd0, carry_flag}, 32'd0);
    check("reset_res_data",   {16'd0, res_data},   32'd0);
    check("reset_alu_in_a",   {16'd0, alu_in_a},   32'd0);

    // Basic add with latency measurement
    ext_write(3'd1, 16'h1234);
    ext_write(3'd2, 16'h0FFF);
    issue(1'b0, 4'b1001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (res_valid) break;
    end
    check("latency_edges", k, 32'd3);
    drain();
    check("carry_after_add", {31'd0, carry_flag}, 32'd0);
    issue(1'b1, 4'b1111, 3'd3, 3'd0, 3'd7, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    drain();

    // Overflow sets carry; logic op leaves it; chained add consumes it
    ext_write(3'd1, 16'hFFFF);
    ext_write(3'd2, 16'h0001);
    issue(1'b0, 4'b1001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();
    check("carry_after_overflow", {31'd0, carry_flag}, 32'd1);
    ext_write(3'd4, 16'hFF00);
    ext_write(3'd5, 16'h0F0F);
    issue(1'b1, 4'b0110, 3'd4, 3'd5, 3'd6, 1'b0, 16'hF00F, 1'b0, 1'b0, 1'b1);
    drain();
    check("carry_after_logic", {31'd0, carry_flag}, 32'd1);
    issue(1'b0, 4'b1001, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("alu_carry_in_chained", {31'd0, alu_carry_in}, 32'd1);
    drain();
    check("carry_after_chain", {31'd0, carry_flag}, 32'd0);

    // Back-pressure: results held, no accept, external write dropped
    res_ready = 1'b0;
    issue(1'b1, 4'b1111, 3'd2, 3'd2, 3'd5, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b1);
    k = 0;
    while (!res_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
      check("hold_res_data",  {16'd0, res_data},  32'h0001);
      check("hold_ins_ready", {31'd0, ins_ready}, 32'd0);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    res_ready = 1'b1;
    drain();
    issue(1'b1, 4'b1111, 3'd1, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    drain();

    // External write in the accept cycle is seen by DRIVE
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA;
    issue(1'b1, 4'b1111, 3'd1, 3'd1, 3'd4, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b1);
    wr_en = 1'b0;
    drain();

    // rd == ra: operands read before write-back
    issue(1'b0, 4'b1001, 3'd1, 3'd2, 3'd1, 1'b0, 16'hAAAB, 1'b0, 1'b0, 1'b1);
    drain();
    issue(1'b1, 4'b1111, 3'd1, 3'd0, 3'd6, 1'b0, 16'hAAAB, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset during CAPT
    ext_write(3'd1, 16'hFFFF);
    issue(1'b0, 4'b1001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();
    check("carry_before_rst", {31'd0, carry_flag}, 32'd1);
    issue(1'b0, 4'b1001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_res_valid",  {31'd0, res_valid},  32'd0);
    check("rst_carry_flag", {31'd0, carry_flag}, 32'd0);
    check("rst_res_data",   {16'd0, res_data},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ins_ready", {31'd0, ins_ready}, 32'd1);
    for (int r = 0; r < 8; r++) begin
      issue(1'b1, 4'b1111, 3'(r), 3'd0, 3'(r), 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
